// File: rtl/ram_1rw_arb_s.sv
// Single-port RAM fronted by an NCH-way valid/ready arbiter (round-robin or fixed priority).
// Reads return through a 1- or 2-stage pipeline tagged with the requesting channel.
module ram_1rw_arb_s #(
  parameter int NCH     = 4,
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MASKW   = 4,
  parameter int OUT_REG = 1,
  parameter int RR      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       req_valid,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH-1:0]       req_we,
  input  logic [NCH*AW-1:0]    req_addr,
  input  logic [NCH*DW-1:0]    req_wdata,
  input  logic [NCH*MASKW-1:0] req_wmask_n,
  output logic [NCH-1:0]       rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 busy
);
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int L      = DW / MASKW;
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  logic [NCH-1:0][AW-1:0]    addr_v;
  logic [NCH-1:0][DW-1:0]    wdata_v;
  logic [NCH-1:0][MASKW-1:0] mask_v;
  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign mask_v  = req_wmask_n;

  logic [CW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] gnt;
  logic [CW-1:0]  gnt_idx, idx;
  logic           found;

  // Search upward from the pointer with wrap; first valid channel wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = CW'((int'(ptr_q) + k) % NCH);
      if (!found && req_valid[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  assign req_ready = reset ? '0 : gnt;

  logic            acc, acc_rd, sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [MASKW-1:0] sel_mask_n;

  assign acc        = |(req_valid & req_ready);
  assign sel_we     = req_we[gnt_idx];
  assign sel_addr   = addr_v[gnt_idx];
  assign sel_wdata  = wdata_v[gnt_idx];
  assign sel_mask_n = mask_v[gnt_idx];
  assign acc_rd     = acc && !sel_we;

  always_comb begin
    ptr_d = ptr_q;
    if (RR != 0 && acc)
      ptr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Array contents survive reset; only the accepted write touches it.
  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (acc && sel_we)
      for (int i = 0; i < MASKW; i++)
        if (!sel_mask_n[i]) mem_q[sel_addr][i*L +: L] <= sel_wdata[i*L +: L];
  end

  logic [STAGES:1]         vld_q;
  logic [STAGES:1][CW-1:0] tag_q;
  logic [STAGES:1][DW-1:0] dat_q;

  // Data/tag stages only load behind a valid, so rsp_rdata holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      tag_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[1] <= acc_rd;
      if (acc_rd) begin
        tag_q[1] <= gnt_idx;
        dat_q[1] <= mem_q[sel_addr];
      end
      for (int s = 2; s <= STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          tag_q[s] <= tag_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end
  end

  assign rsp_valid = vld_q[STAGES] ? (NCH'(1) << tag_q[STAGES]) : '0;
  assign rsp_rdata = dat_q[STAGES];
  assign busy      = |vld_q;

endmodule

// File: doc/ram_1rw_arb_s.md
Name: ram_1rw_arb_s

Overview:
Parametrised single-port RAM with a built-in N-channel arbiter. It replaces direct per-client ce_n/wr_n wiring to a 1RW macro.
- Up to NCH requestors share one behavioural 1RW array through valid/ready handshakes.
- Arbitration is round-robin or fixed-priority.
- Byte-lane write masks are supported.
- Read latency is fixed and configurable, with an optional output pipeline register.
- Sits between BIO/BDMA-side masters and the RAM array.

Parameters:
NCH, 4, number of requesting channels (1..8)
AW, 10, word address width; depth = 2**AW
DW, 32, data width
MASKW, 4, write-mask lanes; DW % MASKW == 0, lane = DW/MASKW bits
OUT_REG, 1, 0 = read data 1 cycle after grant; 1 = 2 cycles (extra output flop)
RR, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
req_valid  in  NCH  per-channel request valid
req_ready  out  NCH  per-channel grant, combinational from req_valid and the arbiter pointer
req_we  in  NCH  1 = write, 0 = read
req_addr  in  NCH*AW  packed, channel c at [c*AW +: AW]
req_wdata  in  NCH*DW  packed write data
req_wmask_n  in  NCH*MASKW  packed active-low lane enables (0 = write lane)
rsp_valid  out  NCH  one-cycle pulse marking read data for channel c
rsp_rdata  out  DW  read data, shared across channels, qualified by rsp_valid
busy  out  1  high while any read is in the pipeline

Behaviour:
- Reset values (asynchronous):
  - req_ready = 0 while reset is high.
  - rsp_valid = 0, rsp_rdata = 0, busy = 0.
  - Round-robin pointer = 0; pipeline valid/channel tags cleared.
  - Memory contents are not reset (X in simulation).
- Grant:
  - At most one bit of req_ready is high per cycle.
  - The granted channel is the first valid channel at or after the pointer, searching upward with wrap from NCH-1 to 0.
  - With RR=0 the pointer is held at 0.
- Accept: a transfer occurs on the edge where req_valid[c] & req_ready[c]. Exactly one RAM access happens per accepted transfer; no access occurs in idle cycles (internal ce inactive).
- Pointer update (RR=1): after an accept from channel c, pointer = (c+1) mod NCH. With no accept, the pointer is unchanged.
- Write:
  - On accept, each lane i with wmask_n[i]==0 updates mem[addr][i*L +: L].
  - All-ones mask = no-op access; still accepted, no response.
  - Writes never generate rsp_valid.
- Read:
  - On accept, the array read is registered at edge T+1.
  - OUT_REG=0: rsp_valid[c] and rsp_rdata are valid in the cycle after accept (latency 1).
  - OUT_REG=1: latency 2.
  - A channel tag travels with the pipeline stage. rsp_rdata holds its last value when rsp_valid = 0.
- Back-to-back: a new access may be accepted every cycle. Reads from different channels return in acceptance order, one per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data. The array is read-first within a cycle, but accesses are serialised, so no hazard arises.
- Requester rule: a channel must hold req_valid and all request fields stable until accepted. The arbiter must tolerate req_valid dropping before grant (no lock-up, pointer unaffected).
- busy = OR of the pipeline-stage valids.
- Reset mid-operation: in-flight reads are discarded with no rsp_valid. Writes accepted before the reset edge persist.
- Width rules: AW and DW are independent. NCH=1 degenerates to req_ready = req_valid.

Test Plan:
- Single write then read, NCH=4, OUT_REG=1: ch2 writes 0xDEADBEEF to addr 0x3FF with mask_n=0000, then reads it → rsp_valid[2] exactly 2 cycles after read accept, rsp_rdata=0xDEADBEEF, other rsp_valid bits 0.
- Byte mask: write 0x11223344 to addr 5, then write 0xAABBCCDD with mask_n=1010, then read → 0x11BB33DD.
- Round-robin fairness: all four channels hold reads continuously for 8 cycles from reset → grants in order 0,1,2,3,0,1,2,3; with RR=0 → ch0 granted every cycle.
- Wrap and skip: pointer=3, only ch1 and ch3 valid → ch3 granted, then ch1 (pointer wraps to 0), then ch3.
- Latency/OUT_REG=0: read ch0 addr 7, then ch1 addr 8 on consecutive cycles → rsp_valid[0] next cycle with mem[7], then rsp_valid[1] the cycle after with mem[8]; busy high exactly 2 cycles.
- Reset mid-read: accept a read, assert reset asynchronously before the response → rsp_valid stays 0, busy=0, pointer=0. A write accepted earlier reads back correctly after reset release.
